// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the machine-mode CSR file.
// CSR_COUNTERS_EN adds mcycle/minstret to the implemented address set.
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] CsrMstatus  = 12'h300;
  localparam logic [11:0] CsrMtvec    = 12'h305;
  localparam logic [11:0] CsrMscratch = 12'h340;
  localparam logic [11:0] CsrMepc     = 12'h341;
  localparam logic [11:0] CsrMcause   = 12'h342;
  localparam logic [11:0] CsrMcycle   = 12'hB00;
  localparam logic [11:0] CsrMinstret = 12'hB02;

  // mstatus bit positions
  localparam int unsigned MstatusMie   = 3;
  localparam int unsigned MstatusMpie  = 7;
  localparam int unsigned MstatusMppLo = 11;
  localparam int unsigned MstatusMppHi = 12;

  // Reset values and fixed fields
  localparam logic [63:0] MstatusRst = 64'h0000_000A_0000_1800;
  localparam logic [1:0]  MppMachine = 2'b11;

  // mcause codes
  localparam logic [63:0] McauseEcallM = 64'd11;

  // WARL masks: mtvec/mepc are 4-byte aligned, mstatus exposes only MIE/MPIE
  localparam logic [63:0] MtvecWarlMask = ~64'h3;
  localparam logic [63:0] MepcWarlMask  = ~64'h3;
  localparam logic [63:0] MstatusWrMask = 64'h88;

  // True when addr names a CSR held in this file
  function automatic logic csr_implemented(input logic [11:0] addr);
    logic hit;
    hit = 1'b0;
    case (addr)
      CsrMstatus, CsrMtvec, CsrMscratch, CsrMepc, CsrMcause: hit = 1'b1;
`ifdef CSR_COUNTERS_EN
      CsrMcycle, CsrMinstret: hit = 1'b1;
`endif
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// csr_regfile_if: bundle between the CSR execute unit (master) and the
// CSR register file (slave).
interface csr_regfile_if #(
  parameter int unsigned XLEN = 64
);
  logic [11:0]     CSR_Read_Addr;
  logic [XLEN-1:0] CSR_Read_Data;
  logic [11:0]     CSR_Write_Addr;
  logic [XLEN-1:0] CSR_Write_Data;
  logic            Write_En;
  logic [XLEN-1:0] mcause_Write_Data;
  logic [XLEN-1:0] mepc_Write_Data;
  logic [XLEN-1:0] mtvec_Write_Data;
  logic            mcause_En;
  logic            mepc_En;
  logic            mtvec_En;
  logic [XLEN-1:0] mcause_Read_Data;
  logic [XLEN-1:0] mepc_Read_Data;
  logic [XLEN-1:0] mtvec_Read_Data;
  logic            mret_en;
  logic            inst_retire;
  logic            csr_illegal;

  modport master (
    output CSR_Read_Addr, CSR_Write_Addr, CSR_Write_Data, Write_En,
    output mcause_Write_Data, mepc_Write_Data, mtvec_Write_Data,
    output mcause_En, mepc_En, mtvec_En, mret_en, inst_retire,
    input  CSR_Read_Data, mcause_Read_Data, mepc_Read_Data, mtvec_Read_Data,
    input  csr_illegal
  );

  modport slave (
    input  CSR_Read_Addr, CSR_Write_Addr, CSR_Write_Data, Write_En,
    input  mcause_Write_Data, mepc_Write_Data, mtvec_Write_Data,
    input  mcause_En, mepc_En, mtvec_En, mret_en, inst_retire,
    output CSR_Read_Data, mcause_Read_Data, mepc_Read_Data, mtvec_Read_Data,
    output csr_illegal
  );
endinterface

// File: rtl/csr_counter.sv
// csr_counter: free-running XLEN counter with synchronous active-low reset,
// a load port that overrides the increment, and wrap-around at all-ones.
module csr_counter #(
  parameter int unsigned XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_load_data,
  input  logic            i_inc,
  output logic [XLEN-1:0] o_count
);

  logic [XLEN-1:0] r_count;
  logic [XLEN-1:0] w_count_nxt;

  // Next count: load beats increment
  always_comb begin
    w_count_nxt = r_count;
    if (i_load) begin
      w_count_nxt = i_load_data;
    end else if (i_inc) begin
      w_count_nxt = r_count + 1'b1;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR storage for the RV64 NPC core.
// Holds mstatus/mtvec/mscratch/mepc/mcause, sequences mstatus on trap entry
// and mret. Define CSR_COUNTERS_EN to add mcycle (0xB00) and minstret (0xB02).
module csr_regfile
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] MSTATUS_RST = MstatusRst[XLEN-1:0]
) (
  input logic          clk,
  input logic          rst_n,
  csr_regfile_if.slave bus
);

  // Only MIE/MPIE of mstatus are stored; every other bit is constant
  logic            r_mie;
  logic            r_mpie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;

  logic            w_mie_nxt;
  logic            w_mpie_nxt;
  logic [XLEN-1:0] w_mtvec_nxt;
  logic [XLEN-1:0] w_mscratch_nxt;
  logic [XLEN-1:0] w_mepc_nxt;
  logic [XLEN-1:0] w_mcause_nxt;
  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_mcycle;
  logic [XLEN-1:0] w_minstret;

  logic w_trap;
  logic w_wr_mstatus;
  logic w_wr_mtvec;
  logic w_wr_mscratch;
  logic w_wr_mepc;
  logic w_wr_mcause;

  assign w_trap        = bus.mcause_En & bus.mepc_En;
  assign w_wr_mstatus  = bus.Write_En && (bus.CSR_Write_Addr == CsrMstatus);
  assign w_wr_mtvec    = bus.Write_En && (bus.CSR_Write_Addr == CsrMtvec);
  assign w_wr_mscratch = bus.Write_En && (bus.CSR_Write_Addr == CsrMscratch);
  assign w_wr_mepc     = bus.Write_En && (bus.CSR_Write_Addr == CsrMepc);
  assign w_wr_mcause   = bus.Write_En && (bus.CSR_Write_Addr == CsrMcause);

  // Next-state selection: trap > mret > generic for mstatus, dedicated > generic elsewhere
  always_comb begin
    w_mie_nxt      = r_mie;
    w_mpie_nxt     = r_mpie;
    w_mtvec_nxt    = r_mtvec;
    w_mscratch_nxt = r_mscratch;
    w_mepc_nxt     = r_mepc;
    w_mcause_nxt   = r_mcause;

    if (w_trap) begin
      w_mpie_nxt = r_mie;
      w_mie_nxt  = 1'b0;
    end else if (bus.mret_en) begin
      w_mie_nxt  = r_mpie;
      w_mpie_nxt = 1'b1;
    end else if (w_wr_mstatus) begin
      w_mie_nxt  = bus.CSR_Write_Data[MstatusMie];
      w_mpie_nxt = bus.CSR_Write_Data[MstatusMpie];
    end

    if (bus.mtvec_En) begin
      w_mtvec_nxt = bus.mtvec_Write_Data & MtvecWarlMask[XLEN-1:0];
    end else if (w_wr_mtvec) begin
      w_mtvec_nxt = bus.CSR_Write_Data & MtvecWarlMask[XLEN-1:0];
    end

    if (w_wr_mscratch) begin
      w_mscratch_nxt = bus.CSR_Write_Data;
    end

    if (bus.mepc_En) begin
      w_mepc_nxt = bus.mepc_Write_Data & MepcWarlMask[XLEN-1:0];
    end else if (w_wr_mepc) begin
      w_mepc_nxt = bus.CSR_Write_Data & MepcWarlMask[XLEN-1:0];
    end

    if (bus.mcause_En) begin
      w_mcause_nxt = bus.mcause_Write_Data;
    end else if (w_wr_mcause) begin
      w_mcause_nxt = bus.CSR_Write_Data;
    end
  end

  // CSR state; reset overrides every concurrent write, trap or mret
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
    end else begin
      r_mie      <= w_mie_nxt;
      r_mpie     <= w_mpie_nxt;
      r_mtvec    <= w_mtvec_nxt;
      r_mscratch <= w_mscratch_nxt;
      r_mepc     <= w_mepc_nxt;
      r_mcause   <= w_mcause_nxt;
    end
  end

`ifdef CSR_COUNTERS_EN
  logic w_ld_mcycle;
  logic w_ld_minstret;

  assign w_ld_mcycle   = bus.Write_En && (bus.CSR_Write_Addr == CsrMcycle);
  assign w_ld_minstret = bus.Write_En && (bus.CSR_Write_Addr == CsrMinstret);

  csr_counter #(
    .XLEN(XLEN)
  ) u_mcycle (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (w_ld_mcycle),
    .i_load_data(bus.CSR_Write_Data),
    .i_inc      (1'b1),
    .o_count    (w_mcycle)
  );

  csr_counter #(
    .XLEN(XLEN)
  ) u_minstret (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (w_ld_minstret),
    .i_load_data(bus.CSR_Write_Data),
    .i_inc      (bus.inst_retire),
    .o_count    (w_minstret)
  );
`else
  logic w_unused_inst_retire;
  assign w_unused_inst_retire = bus.inst_retire;
  assign w_mcycle             = '0;
  assign w_minstret           = '0;
`endif

  // mstatus view: constant fields from reset value, MPP pinned to machine mode
  always_comb begin
    w_mstatus                            = MSTATUS_RST & ~MstatusWrMask[XLEN-1:0];
    w_mstatus[MstatusMie]                = r_mie;
    w_mstatus[MstatusMpie]               = r_mpie;
    w_mstatus[MstatusMppHi:MstatusMppLo] = MppMachine;
  end

  // Combinational read port; unimplemented addresses read zero
  always_comb begin
    bus.CSR_Read_Data = '0;
    case (bus.CSR_Read_Addr)
      CsrMstatus:  bus.CSR_Read_Data = w_mstatus;
      CsrMtvec:    bus.CSR_Read_Data = r_mtvec;
      CsrMscratch: bus.CSR_Read_Data = r_mscratch;
      CsrMepc:     bus.CSR_Read_Data = r_mepc;
      CsrMcause:   bus.CSR_Read_Data = r_mcause;
`ifdef CSR_COUNTERS_EN
      CsrMcycle:   bus.CSR_Read_Data = w_mcycle;
      CsrMinstret: bus.CSR_Read_Data = w_minstret;
`endif
      default:     bus.CSR_Read_Data = '0;
    endcase
  end

  // Illegal flag: generic write aimed at an address this file does not hold
  always_comb begin
    bus.csr_illegal = bus.Write_En && !csr_implemented(bus.CSR_Write_Addr);
  end

  assign bus.mcause_Read_Data = r_mcause;
  assign bus.mepc_Read_Data   = r_mepc;
  assign bus.mtvec_Read_Data  = r_mtvec;

endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: directed self-checking bench for csr_regfile.
// Counter checks are compiled in when CSR_COUNTERS_EN is defined.
module tb_csr_regfile;

  localparam logic [63:0] Rst = 64'h0000_000A_0000_1800;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  csr_regfile_if #(.XLEN(64)) bus ();

  csr_regfile dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] a, input logic [63:0] exp, input string tag);
    bus.CSR_Read_Addr = a;
    #1;
    chk(tag, bus.CSR_Read_Data, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.Write_En          = 1'b0;
    bus.CSR_Write_Addr    = 12'h0;
    bus.CSR_Write_Data    = 64'h0;
    bus.mcause_En         = 1'b0;
    bus.mepc_En           = 1'b0;
    bus.mtvec_En          = 1'b0;
    bus.mcause_Write_Data = 64'h0;
    bus.mepc_Write_Data   = 64'h0;
    bus.mtvec_Write_Data  = 64'h0;
    bus.mret_en           = 1'b0;
    bus.inst_retire       = 1'b0;
  endtask

  task automatic gw(input logic [11:0] a, input logic [63:0] d);
    bus.Write_En       = 1'b1;
    bus.CSR_Write_Addr = a;
    bus.CSR_Write_Data = d;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    idle();
    bus.CSR_Read_Addr = 12'h0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Reset state
    rd(12'h300, Rst, "rst_mstatus");
    rd(12'h305, 64'h0, "rst_mtvec");
    rd(12'h341, 64'h0, "rst_mepc");
    rd(12'h342, 64'h0, "rst_mcause");
    rd(12'h340, 64'h0, "rst_mscratch");
    chk("rst_mcause_view", bus.mcause_Read_Data, 64'h0);
    chk("rst_illegal", {63'h0, bus.csr_illegal}, 64'h0);

    // mtvec WARL, plus same-cycle read sees old value
    gw(12'h305, 64'h8000_0103);
    rd(12'h305, 64'h0, "mtvec_old_same_cycle");
    tick();
    idle();
    rd(12'h305, 64'h8000_0100, "mtvec_warl");
    chk("mtvec_view", bus.mtvec_Read_Data, 64'h8000_0100);

    // mscratch full-width
    gw(12'h340, 64'hDEAD_BEEF);
    tick();
    idle();
    rd(12'h340, 64'hDEAD_BEEF, "mscratch");

    // Unimplemented address
    gw(12'h7C0, 64'h1234);
    #1;
    chk("illegal_7c0", {63'h0, bus.csr_illegal}, 64'h1);
`ifndef CSR_COUNTERS_EN
    bus.CSR_Write_Addr = 12'hB00;
    #1;
    chk("illegal_b00", {63'h0, bus.csr_illegal}, 64'h1);
`endif
    tick();
    idle();
    #1;
    chk("illegal_clear", {63'h0, bus.csr_illegal}, 64'h0);
    rd(12'h7C0, 64'h0, "rd_unimpl");
`ifndef CSR_COUNTERS_EN
    rd(12'hB00, 64'h0, "rd_b00_absent");
    rd(12'hB02, 64'h0, "rd_b02_absent");
`endif

    // mstatus WARL
    gw(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    idle();
    rd(12'h300, 64'h0000_000A_0000_1888, "mstatus_all_ones");
    gw(12'h300, 64'h8);
    tick();
    idle();
    rd(12'h300, 64'h0000_000A_0000_1808, "mstatus_mie");

    // Trap entry
    bus.mcause_En = 1'b1; bus.mcause_Write_Data = 64'd11;
    bus.mepc_En   = 1'b1; bus.mepc_Write_Data   = 64'h8000_0010;
    tick();
    idle();
    chk("trap_mcause", bus.mcause_Read_Data, 64'd11);
    chk("trap_mepc", bus.mepc_Read_Data, 64'h8000_0010);
    rd(12'h300, 64'h0000_000A_0000_1880, "trap_mstatus");
    rd(12'h342, 64'd11, "trap_mcause_rd");

    // mret
    bus.mret_en = 1'b1;
    tick();
    idle();
    rd(12'h300, 64'h0000_000A_0000_1888, "mret_mstatus");

    // Trap and mret together: trap wins
    bus.mcause_En = 1'b1; bus.mcause_Write_Data = 64'd2;
    bus.mepc_En   = 1'b1; bus.mepc_Write_Data   = 64'h8000_0020;
    bus.mret_en   = 1'b1;
    tick();
    idle();
    rd(12'h300, 64'h0000_000A_0000_1880, "trap_beats_mret");
    chk("trap_mret_mcause", bus.mcause_Read_Data, 64'd2);

    // mret beats generic mstatus write
    bus.mret_en = 1'b1;
    gw(12'h300, 64'h0);
    tick();
    idle();
    rd(12'h300, 64'h0000_000A_0000_1888, "mret_beats_write");

    // Dedicated mcause write beats generic; lone mcause_En is not a trap
    gw(12'h342, 64'd5);
    bus.mcause_En = 1'b1; bus.mcause_Write_Data = 64'd11;
    tick();
    idle();
    chk("collide_mcause", bus.mcause_Read_Data, 64'd11);
    rd(12'h300, 64'h0000_000A_0000_1888, "no_trap_mstatus");

    // Generic write to another register commits alongside a dedicated write
    gw(12'h340, 64'h1234);
    bus.mtvec_En = 1'b1; bus.mtvec_Write_Data = 64'h203;
    tick();
    idle();
    rd(12'h340, 64'h1234, "parallel_mscratch");
    chk("mtvec_ded_warl", bus.mtvec_Read_Data, 64'h200);

    // mepc generic WARL
    gw(12'h341, 64'h8000_0047);
    tick();
    idle();
    chk("mepc_warl", bus.mepc_Read_Data, 64'h8000_0044);

    // Reset dominates everything pending
    rst_n = 1'b0;
    gw(12'h340, 64'h55);
    bus.mcause_En = 1'b1; bus.mcause_Write_Data = 64'd7;
    bus.mepc_En   = 1'b1; bus.mepc_Write_Data   = 64'h100;
    bus.mtvec_En  = 1'b1; bus.mtvec_Write_Data  = 64'h400;
    bus.mret_en   = 1'b1;
    tick();
    rst_n = 1'b1;
    idle();
    rd(12'h300, Rst, "midrst_mstatus");
    rd(12'h340, 64'h0, "midrst_mscratch");
    chk("midrst_mcause", bus.mcause_Read_Data, 64'h0);
    chk("midrst_mepc", bus.mepc_Read_Data, 64'h0);
    chk("midrst_mtvec", bus.mtvec_Read_Data, 64'h0);
    gw(12'h340, 64'h77);
    tick();
    idle();
    rd(12'h340, 64'h77, "post_rst_write");
    rd(12'h300, Rst, "post_rst_mstatus");

`ifdef CSR_COUNTERS_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.inst_retire = (i < 4);
      tick();
    end
    bus.inst_retire = 1'b0;
    rd(12'hB00, 64'd10, "mcycle_10");
    rd(12'hB02, 64'd4, "minstret_4");
    gw(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    #1;
    chk("mcycle_legal", {63'h0, bus.csr_illegal}, 64'h0);
    tick();
    idle();
    tick();
    tick();
    rd(12'hB00, 64'd1, "mcycle_wrap");
    gw(12'hB02, 64'd100);
    bus.inst_retire = 1'b1;
    tick();
    idle();
    rd(12'hB02, 64'd100, "minstret_load");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/csr_regfile.md
# csr_regfile

Machine-mode control/status register file for the RV64 NPC core. It is the storage and responder side of the CSR execute unit. It serves that unit's combinational CSR read port and commits its generic and dedicated (mcause/mepc/mtvec) writes on the clock edge. It also sequences mstatus on trap entry and mret, and optionally keeps the mcycle/minstret counters.

## Interface
Parameters:
- XLEN, 64, register and data width.
- MSTATUS_RST, 64'h0000_000A_0000_1800, mstatus reset value (MPP=11, UXL/SXL=10).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- CSR_Read_Addr  input  12  generic read address.
- CSR_Read_Data  output  XLEN  combinational read data.
- CSR_Write_Addr  input  12  generic write address.
- CSR_Write_Data  input  XLEN  generic write data.
- Write_En  input  1  generic write strobe.
- mcause_Write_Data / mepc_Write_Data / mtvec_Write_Data  input  XLEN  dedicated write data.
- mcause_En / mepc_En / mtvec_En  input  1  dedicated write strobes.
- mcause_Read_Data / mepc_Read_Data / mtvec_Read_Data  output  XLEN  direct register views.
- mret_en  input  1  mret commit strobe.
- inst_retire  input  1  one instruction retired this cycle.
- csr_illegal  output  1  combinational; Write_En to an unimplemented or read-only address.

## Operation
- Implemented: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342. The macro adds mcycle 0xB00 and minstret 0xB02 (read/write).
- Read: CSR_Read_Data = decoded register, same cycle. Unimplemented address returns 0.
- Generic write: on the edge with Write_En=1, the addressed register gets CSR_Write_Data. Unimplemented addresses are ignored and raise csr_illegal.
- WARL rules:
  - mtvec[1:0] forced 00 (direct mode only).
  - mepc[1:0] forced 00.
  - mstatus writable bits: MIE[3], MPIE[7]. MPP[12:11] reads fixed 11. All other bits hold their reset value.
- Dedicated writes take priority over a generic write to the same register in the same cycle. Generic writes to other registers still commit.
- Trap entry = mcause_En & mepc_En. On that edge: MPIE<=MIE, MIE<=0, MPP stays 11.
- mret (mret_en=1): MIE<=MPIE, MPIE<=1.
- Trap entry and mret in the same cycle: trap wins, mret dropped.
- mstatus update priority: trap sequencing > mret > generic write.

## Timing
- Reads are 0-latency. A write is visible on CSR_Read_Data and the *_Read_Data outputs starting the cycle after its edge.
- Read of a register written in the same cycle returns the old value. No bypass.
- Reset (rst_n=0 at an edge) sets:
  - mstatus = MSTATUS_RST.
  - All other registers and counters = 0.
  - Reset dominates every concurrent write, trap or mret.
- Reset mid-sequence: pending effects are discarded; the next edge after deassertion behaves as normal.
- Counters (with macro):
  - mcycle increments every non-reset edge.
  - minstret increments on edges with inst_retire=1.
  - A CSR write to a counter replaces that edge's increment.
  - Counters wrap 2^64-1 -> 0.

## Configuration
- CSR_COUNTERS_EN defined: mcycle/minstret present as above.
- Undefined: addresses 0xB00/0xB02 are unimplemented (read 0, write sets csr_illegal). inst_retire is ignored and no counter flops exist.

## Structure
- Package csr_pkg holds:
  - 12-bit CSR address constants.
  - MSTATUS bit indices (MIE=3, MPIE=7, MPP=12:11).
  - Reset constants.
  - mcause code constants (ECALL_M=11).
  - WARL masks.
- Sub-module csr_counter: XLEN counter with synchronous active-low reset, load port (priority) and increment enable. Instantiated twice under CSR_COUNTERS_EN.

## Test plan
- Reset: hold rst_n=0 one edge -> mstatus reads 0x0000000A00001800; mtvec/mepc/mcause/mscratch read 0; csr_illegal=0.
- Generic write and WARL:
  - Write mtvec=0x80000103 -> next cycle reads 0x80000100.
  - Write mscratch=0xDEADBEEF -> reads back exactly.
  - Same-cycle read returns the old value.
- Trap entry:
  - Set mstatus MIE=1 (write 0x8).
  - Pulse mcause_En/mepc_En with 11 and 0x80000010 -> mcause=11, mepc=0x80000010, mstatus MIE=0, MPIE=1.
- mret: after the trap above, pulse mret_en -> MIE=1, MPIE=1. Trap and mret in the same cycle -> trap result only.
- Write collision: Write_En to 0x342 with 5, plus mcause_En with 11 on the same edge -> mcause=11.
- Counters (CSR_COUNTERS_EN):
  - 10 edges, inst_retire high on 4 of them -> mcycle=10, minstret=4.
  - Write mcycle=0xFFFFFFFFFFFFFFFF -> after 2 edges reads 1.
  - Without the macro, a write to 0xB00 raises csr_illegal and reads return 0.
